// File: rtl/mips_cpu_run_ctrl_pkg.sv
// Shared types for the MIPS CPU run controller: FSM states, completion codes,
// stall-mode selectors and the stall LFSR step function.
package mips_cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_HOLD,
    ST_WAIT_ACTIVE,
    ST_RUN,
    ST_DONE
  } run_state_t;

  typedef enum logic [1:0] {
    FC_NONE        = 2'd0,
    FC_NO_ACTIVE   = 2'd1,
    FC_TIMEOUT     = 2'd2,
    FC_V0_MISMATCH = 2'd3
  } fail_code_t;

  localparam int STALL_NONE     = 0;
  localparam int STALL_PERIODIC = 1;
  localparam int STALL_LFSR     = 2;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/mips_cpu_run_ctrl_if.sv
// Control/status link between the run controller (master) and the Harvard MIPS CPU (slave).
interface mips_cpu_run_ctrl_if;
  logic        cpu_reset;
  logic        cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] cpu_register_v0;

  modport master (output cpu_reset, output cpu_clk_enable,
                  input  cpu_active, input cpu_register_v0);
  modport slave  (input  cpu_reset, input cpu_clk_enable,
                  output cpu_active, output cpu_register_v0);
endinterface

// File: rtl/mips_cpu_run_ctrl_v0_history.sv
// Circular trace of register_v0 values; read index 0 is always the oldest retained entry.
module mips_cpu_v0_history #(
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
  output logic [31:0]                   rd_data,
  output logic [$clog2(HIST_DEPTH):0]   count
);
  localparam int             IDX_W = $clog2(HIST_DEPTH);
  localparam logic [IDX_W:0] FULL  = (IDX_W + 1)'(HIST_DEPTH);

  logic [31:0]      mem_q [HIST_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, base;
  logic [IDX_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (count_q != FULL) count_d = count_q + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  // once the buffer has wrapped, the write pointer sits on the oldest entry
  assign base    = (count_q == FULL) ? wr_ptr_q : '0;
  assign rd_data = mem_q[base + rd_idx];
  assign count   = count_q;

endmodule

// File: rtl/mips_cpu_run_ctrl.sv
// Run controller for the Harvard MIPS CPU: reset sequencing, clk_enable gating with
// optional stall injection, timeout, final v0 check and a v0 trace buffer.
module mips_cpu_run_ctrl
  import mips_cpu_run_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 100,
  parameter int         RESET_CYCLES   = 1,
  parameter int         STALL_MODE     = 0,
  parameter int         STALL_PERIOD   = 4,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         CNT_W          = 32,
  parameter int         HIST_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          check_en,
  input  logic [31:0]                   expected_v0,
  mips_cpu_run_ctrl_if.master           cpu,
  output logic                          done,
  output logic                          pass,
  output logic [1:0]                    fail_code,
  output logic [31:0]                   final_v0,
  output logic [CNT_W-1:0]              cycle_count,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [31:0]                   hist_rd_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);
  localparam int                RST_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int                STALL_W     = $clog2(STALL_PERIOD);
  localparam logic [RST_W-1:0]   RST_LAST    = RST_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(STALL_PERIOD - 1);
  localparam logic [CNT_W-1:0]   CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  run_state_t         state_q, state_d;
  fail_code_t         fail_code_q, fail_code_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               done_q, done_d, pass_q, pass_d, check_en_l_q, check_en_l_d;
  logic [31:0]        final_v0_q, final_v0_d, expected_l_q, expected_l_d, last_v0_q, last_v0_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               stall, clk_en, hist_clear, hist_wr_en;
  logic [$clog2(HIST_DEPTH):0] hist_count_w;

  always_comb begin
    case (STALL_MODE)
      STALL_PERIODIC: stall = (stall_cnt_q == STALL_LAST);
      STALL_LFSR:     stall = (lfsr_q[1:0] == 2'b00);
      default:        stall = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    lfsr_d        = lfsr_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_code_d   = fail_code_q;
    final_v0_d    = final_v0_q;
    cycle_count_d = cycle_count_q;
    check_en_l_d  = check_en_l_q;
    expected_l_d  = expected_l_q;
    last_v0_d     = last_v0_q;
    clk_en        = 1'b0;
    hist_clear    = 1'b0;
    hist_wr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RESET_HOLD;
          rst_cnt_d     = '0;
          stall_cnt_d   = '0;
          lfsr_d        = LFSR_SEED;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_code_d   = FC_NONE;
          cycle_count_d = '0;
          check_en_l_d  = check_en;
          expected_l_d  = expected_v0;
          hist_clear    = 1'b1;
        end
      end
      ST_RESET_HOLD: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_ACTIVE;
        else rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      ST_WAIT_ACTIVE: begin
        clk_en = 1'b1;
        if (!cpu.cpu_active) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_code_d = FC_NO_ACTIVE;
          final_v0_d  = cpu.cpu_register_v0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        clk_en      = !stall;
        stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + STALL_W'(1);
        lfsr_d      = lfsr_next(lfsr_q);
        hist_wr_en  = (hist_count_w == '0) || (cpu.cpu_register_v0 != last_v0_q);
        if (hist_wr_en) last_v0_d = cpu.cpu_register_v0;
        // completion is checked first so it wins over a timeout in the same cycle
        if (!cpu.cpu_active) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          final_v0_d = cpu.cpu_register_v0;
          pass_d     = !check_en_l_q || (cpu.cpu_register_v0 == expected_l_q);
          fail_code_d = pass_d ? FC_NONE : FC_V0_MISMATCH;
        end else if (cycle_count_q == CNT_TIMEOUT) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_code_d = FC_TIMEOUT;
          final_v0_d  = cpu.cpu_register_v0;
        end else if (clk_en) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      lfsr_q        <= LFSR_SEED;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= FC_NONE;
      final_v0_q    <= '0;
      cycle_count_q <= '0;
      check_en_l_q  <= 1'b0;
      expected_l_q  <= '0;
      last_v0_q     <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      lfsr_q        <= lfsr_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      final_v0_q    <= final_v0_d;
      cycle_count_q <= cycle_count_d;
      check_en_l_q  <= check_en_l_d;
      expected_l_q  <= expected_l_d;
      last_v0_q     <= last_v0_d;
    end
  end

  mips_cpu_v0_history #(.HIST_DEPTH(HIST_DEPTH)) u_hist (
    .clk     (clk),
    .reset   (reset),
    .clear   (hist_clear),
    .wr_en   (hist_wr_en),
    .wr_data (cpu.cpu_register_v0),
    .rd_idx  (hist_rd_idx),
    .rd_data (hist_rd_data),
    .count   (hist_count_w)
  );

  assign cpu.cpu_reset      = reset | (state_q == ST_RESET_HOLD);
  assign cpu.cpu_clk_enable = clk_en & !reset;
  assign done               = done_q;
  assign pass               = pass_q;
  assign fail_code          = fail_code_q;
  assign final_v0           = final_v0_q;
  assign cycle_count        = cycle_count_q;
  assign hist_count         = hist_count_w;

endmodule

// File: tb/tb_mips_cpu_run_ctrl.sv
// Bench for mips_cpu_run_ctrl: three controllers (periodic, LFSR, no stalls) each driving a
// behavioural CPU model; expected results derived per run from the run rules.
module tb_mips_cpu_run_ctrl;
  localparam int         ND   = 3;
  localparam int         TO   = 20;
  localparam int         SP   = 4;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         SM [ND] = '{1, 2, 0};
  localparam int         RC [ND] = '{3, 2, 1};
  localparam int         HD [ND] = '{8, 4, 8};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start [ND];
  logic        check_en [ND];
  logic [31:0] expected_v0 [ND];
  int          ridx [ND];
  logic        done_w [ND], pass_w [ND], cpu_rst_w [ND], cpu_en_w [ND];
  logic [1:0]  fc_w [ND];
  logic [31:0] fv0_w [ND], cc_w [ND], hrd_w [ND];
  logic [3:0]  hcnt_w [ND];

  // CPU model state
  logic        active_r [ND];
  logic [31:0] v0_r [ND];
  int          mcnt [ND];
  int          mlimit [ND];
  logic        mdead [ND];
  logic [31:0] vals [ND][64];

  int n_vec = 0;
  int n_mis = 0;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int HDG = HD[gi];
    localparam int IW  = $clog2(HDG);
    logic [IW:0]   hc;
    logic [IW-1:0] ri;
    mips_cpu_run_ctrl_if cpu_if ();
    assign cpu_if.cpu_active      = active_r[gi];
    assign cpu_if.cpu_register_v0 = v0_r[gi];
    assign cpu_rst_w[gi]          = cpu_if.cpu_reset;
    assign cpu_en_w[gi]           = cpu_if.cpu_clk_enable;
    assign hcnt_w[gi]             = 4'(hc);
    assign ri                     = IW'(ridx[gi]);
    mips_cpu_run_ctrl #(
      .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC[gi]), .STALL_MODE(SM[gi]), .STALL_PERIOD(SP),
      .LFSR_SEED(SEED), .CNT_W(32), .HIST_DEPTH(HDG)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[gi]), .check_en(check_en[gi]),
      .expected_v0(expected_v0[gi]), .cpu(cpu_if), .done(done_w[gi]), .pass(pass_w[gi]),
      .fail_code(fc_w[gi]), .final_v0(fv0_w[gi]), .cycle_count(cc_w[gi]),
      .hist_rd_idx(ri), .hist_rd_data(hrd_w[gi]), .hist_count(hc)
    );
  end

  // CPU model: active stays high for mlimit enabled cycles after the first one, v0 = vals[count]
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (cpu_rst_w[d]) begin
        mcnt[d]     <= 0;
        active_r[d] <= !mdead[d];
        v0_r[d]     <= vals[d][0];
      end else if (cpu_en_w[d]) begin
        mcnt[d]     <= mcnt[d] + 1;
        active_r[d] <= !mdead[d] && (mcnt[d] + 1 <= mlimit[d]);
        v0_r[d]     <= vals[d][(mcnt[d] + 1 > 63) ? 63 : mcnt[d] + 1];
      end
    end
  end

  task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL d%0d_%s: observed %0h expected %0h", d, tag, obs, exp);
    end
  endtask

  task automatic fill_const(input int d, input logic [31:0] v);
    for (int c = 0; c < 64; c++) vals[d][c] = v;
  endtask

  task automatic fill_ramp(input int d);
    for (int c = 0; c < 64; c++) vals[d][c] = 32'(c);
  endtask

  task automatic fill_rand(input int d);
    vals[d][0] = 32'($urandom_range(0, 15));
    for (int c = 1; c < 64; c++)
      vals[d][c] = ($urandom_range(0, 2) == 0) ? vals[d][c-1] : 32'($urandom_range(0, 15));
  endtask

  task automatic run_case(input int d, input int n, input logic dead, input logic ce,
                          input logic [31:0] exp_v0);
    int          rcnt, m, en_seen;
    logic        tmo, e;
    logic [1:0]  fc_ref;
    logic [7:0]  l;
    logic [63:0] tr_bits, ref_bits;
    logic        tr [$];
    logic        en_ref [$];
    logic [31:0] seen [$];
    mlimit[d]      = n;
    mdead[d]       = dead;
    check_en[d]    = ce;
    expected_v0[d] = exp_v0;
    start[d]       = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    rcnt = 0;
    for (int k = 0; k < 400 && !done_w[d]; k++) begin
      if (cpu_rst_w[d]) rcnt++;
      else tr.push_back(cpu_en_w[d]);
      @(negedge clk);
    end
    chk(d, "done", 64'(done_w[d]), 64'd1);
    chk(d, "reset_len", 64'(rcnt), 64'(RC[d]));

    // reference: one probe cycle, then RUN until one cycle past the m-th enabled cycle
    m   = (n < TO) ? n : TO;
    tmo = !dead && (n > TO);
    en_ref.push_back(1'b1);
    if (!dead) begin
      l = SEED;
      en_seen = 0;
      for (int i = 0; i < 200; i++) begin
        e = (SM[d] == 1) ? ((i % SP) != SP - 1) : (SM[d] == 2) ? (l[1:0] != 2'b00) : 1'b1;
        en_ref.push_back(e);
        if (en_seen == m) break;
        if (e) en_seen++;
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      for (int c = 1; c <= m + 1; c++)
        if (seen.size() == 0 || seen[$] != vals[d][c]) seen.push_back(vals[d][c]);
    end
    tr_bits = '0;
    ref_bits = '0;
    foreach (tr[k]) if (k < 64) tr_bits[k] = tr[k];
    foreach (en_ref[k]) if (k < 64) ref_bits[k] = en_ref[k];
    chk(d, "en_len", 64'(tr.size()), 64'(en_ref.size()));
    chk(d, "en_trace", tr_bits, ref_bits);

    fc_ref = dead ? 2'd1 : tmo ? 2'd2 : (ce && vals[d][m+1] != exp_v0) ? 2'd3 : 2'd0;
    chk(d, "fail_code", 64'(fc_w[d]), 64'(fc_ref));
    chk(d, "pass", 64'(pass_w[d]), 64'(fc_ref == 2'd0));
    chk(d, "cycle_count", 64'(cc_w[d]), dead ? 64'd0 : 64'(m));
    if (!dead && !tmo) chk(d, "final_v0", 64'(fv0_w[d]), 64'(vals[d][m+1]));
    while (seen.size() > HD[d]) void'(seen.pop_front());
    chk(d, "hist_count", 64'(hcnt_w[d]), 64'(seen.size()));
    foreach (seen[i]) begin
      ridx[d] = i;
      #2;
      chk(d, $sformatf("hist%0d", i), 64'(hrd_w[d]), 64'(seen[i]));
      @(negedge clk);
    end
    chk(d, "hold_done", 64'(done_w[d]), 64'd1);
    chk(d, "hold_en", 64'(cpu_en_w[d]), 64'd0);
    chk(d, "hold_rst", 64'(cpu_rst_w[d]), 64'd0);
    $display("run d%0d n=%0d dead=%0d chk=%0d exp=%0h -> fail_code=%0d pass=%0d count=%0d hist=%0d",
             d, n, dead, ce, exp_v0, fc_w[d], pass_w[d], cc_w[d], hcnt_w[d]);
  endtask

  initial begin
    int          n, m;
    logic        dead, ce;
    logic [31:0] ev;
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      start[d] = 1'b0;
      check_en[d] = 1'b0;
      expected_v0[d] = '0;
      ridx[d] = 0;
      mlimit[d] = 1;
      mdead[d] = 1'b0;
      fill_const(d, 32'h0);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk(d, "rst_done", 64'(done_w[d]), 64'd0);
      chk(d, "rst_pass", 64'(pass_w[d]), 64'd0);
      chk(d, "rst_fc", 64'(fc_w[d]), 64'd0);
      chk(d, "rst_fv0", 64'(fv0_w[d]), 64'd0);
      chk(d, "rst_cc", 64'(cc_w[d]), 64'd0);
      chk(d, "rst_hcnt", 64'(hcnt_w[d]), 64'd0);
      chk(d, "rst_en", 64'(cpu_en_w[d]), 64'd0);
      chk(d, "rst_cpu_rst", 64'(cpu_rst_w[d]), 64'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk(d, "idle_cpu_rst", 64'(cpu_rst_w[d]), 64'd0);

    // directed: no stalls, pass / mismatch / check disabled / timeout / history wrap
    fill_const(2, 32'h5);
    run_case(2, 10, 1'b0, 1'b1, 32'h5);
    run_case(2, 10, 1'b0, 1'b1, 32'h6);
    run_case(2, 10, 1'b0, 1'b0, 32'h6);
    run_case(2, 40, 1'b0, 1'b1, 32'h5);
    fill_ramp(2);
    run_case(2, 11, 1'b0, 1'b0, 32'h0);
    // periodic stalls over 9 enabled cycles; CPU never active with a 3-cycle reset
    fill_const(0, 32'h5);
    run_case(0, 9, 1'b0, 1'b1, 32'h5);
    run_case(0, 9, 1'b1, 1'b1, 32'h5);
    fill_ramp(1);
    run_case(1, 12, 1'b0, 1'b1, 32'd13);

    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < ND; d++) begin
        fill_rand(d);
        n    = $urandom_range(1, 26);
        dead = ($urandom_range(0, 7) == 0);
        ce   = 1'($urandom_range(0, 1));
        m    = (n < TO) ? n : TO;
        ev   = ($urandom_range(0, 1) == 1) ? vals[d][m+1] : 32'($urandom_range(0, 15));
        run_case(d, n, dead, ce, ev);
      end
    end

    // reset in the middle of a run
    fill_ramp(0);
    mlimit[0] = 50;
    mdead[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk(0, "mid_done", 64'(done_w[0]), 64'd0);
    reset = 1'b1;
    #1;
    chk(0, "mid_cpu_rst", 64'(cpu_rst_w[0]), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    chk(0, "mid_hcnt", 64'(hcnt_w[0]), 64'd0);
    chk(0, "mid_cc", 64'(cc_w[0]), 64'd0);
    chk(0, "mid_done2", 64'(done_w[0]), 64'd0);
    @(negedge clk);
    chk(0, "mid_idle_en", 64'(cpu_en_w[0]), 64'd0);
    chk(0, "mid_idle_rst", 64'(cpu_rst_w[0]), 64'd0);
    $display("mid-run reset d0 -> done=%0d hist=%0d count=%0d", done_w[0], hcnt_w[0], cc_w[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
